// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter sharing the register file's single write port among four
// requesters with a valid/ready handshake, plus a 32-cycle bulk clear sequencer.
// The register file gates its clock with RegWrite, so the rf_* outputs come from
// falling-edge flops and stay constant while clk is high.
module regfile_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  rf_write,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic [1:0]            grant_id,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    logic [1:0]          rr_ptr_r;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic                stage_wr_r;
    logic [ADDR_W-1:0]   stage_addr_r;
    logic [DATA_W-1:0]   stage_data_r;
    logic [7:0]          drop_cnt_r;

    logic [1:0]          winner_s;
    logic                arb_open_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_data_s;
    logic                win_zero_s;

    // First asserted requester found when scanning upward from ptr, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Combinational grant: one-hot ready toward the winner while arbitrating; held low in reset.
    always_comb begin
        winner_s   = rr_pick(req_valid, rr_ptr_r);
        arb_open_s = reset && (state_r == ST_ARB) && !clear_start && (|req_valid);
        win_addr_s = req_addr[int'(winner_s)*ADDR_W +: ADDR_W];
        win_data_s = req_data[int'(winner_s)*DATA_W +: DATA_W];
        win_zero_s = ZERO_R0 && (win_addr_s == {ADDR_W{1'b0}});
        if (arb_open_s) begin
            req_ready = 4'b0001 << winner_s;
            grant_id  = winner_s;
        end else begin
            req_ready = 4'b0000;
            grant_id  = 2'd0;
        end
    end

    // Arbitration / clear FSM and the write stage register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= 2'd0;
            clr_cnt_r    <= {ADDR_W{1'b0}};
            stage_wr_r   <= 1'b0;
            stage_addr_r <= {ADDR_W{1'b0}};
            stage_data_r <= {DATA_W{1'b0}};
            drop_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (clear_start) begin
                        // Clear wins over any simultaneous request; arbitration restarts at 0.
                        state_r    <= ST_CLEAR;
                        clr_cnt_r  <= {ADDR_W{1'b0}};
                        rr_ptr_r   <= 2'd0;
                        stage_wr_r <= 1'b0;
                    end else if (|req_valid) begin
                        stage_addr_r <= win_addr_s;
                        stage_data_r <= win_data_s;
                        stage_wr_r   <= !win_zero_s;
                        rr_ptr_r     <= winner_s + 2'd1;
                        if (win_zero_s && (drop_cnt_r != 8'hFF)) begin
                            drop_cnt_r <= drop_cnt_r + 8'd1;
                        end else begin
                            drop_cnt_r <= drop_cnt_r;
                        end
                    end else begin
                        stage_wr_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // r0 suppression during clear is silent: drop_cnt is untouched.
                    stage_addr_r <= clr_cnt_r;
                    stage_data_r <= {DATA_W{1'b0}};
                    stage_wr_r   <= !(ZERO_R0 && (clr_cnt_r == {ADDR_W{1'b0}}));
                    clr_cnt_r    <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                default: begin
                    state_r    <= ST_ARB;
                    stage_wr_r <= 1'b0;
                end
            endcase
        end
    end

    // Falling-edge output flops so RegWrite never moves while clk is high.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rf_write <= 1'b0;
            rf_addr  <= {ADDR_W{1'b0}};
            rf_data  <= {DATA_W{1'b0}};
        end else begin
            rf_write <= stage_wr_r;
            rf_addr  <= stage_addr_r;
            rf_data  <= stage_data_r;
        end
    end

    assign clear_busy = (state_r == ST_CLEAR);
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register file among four write requesters, such as ALU writeback, load unit, multiply unit and debug, using round-robin arbitration and a valid/ready handshake. It also sequences a 32-cycle bulk clear of the register file on command. The block sits directly in front of the register file's WriteReg/WriteData/RegWrite inputs. The register file gates its clock with RegWrite, so this block drives those signals from falling-edge flops to keep them stable while clk is high.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- ZERO_R0, 1, when 1 every write to address 0 is accepted but suppressed (rf_write stays 0)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- req_valid  in  4  per-requester write request
- req_addr  in  4×ADDR_W  packed; requester i at [i*5+4:i*5]
- req_data  in  4×DATA_W  packed; requester i at [i*32+31:i*32]
- req_ready  out  4  one-hot grant; handshake completes when valid&ready at posedge
- clear_start  in  1  single-cycle pulse requesting bulk clear
- clear_busy  out  1  high while the clear sequence runs
- rf_write  out  1  to register file RegWrite
- rf_addr  out  ADDR_W  to WriteReg
- rf_data  out  DATA_W  to WriteData
- grant_id  out  2  index of the requester granted in the current cycle (valid when |req_ready)
- drop_cnt  out  8  saturating count of suppressed r0 writes

## Operation
- States: ARB, CLEAR.
- ARB:
  - The winner is chosen combinationally from the set of asserted req_valid bits.
  - Search starts at rr_ptr and wraps 3→0. The first asserted requester wins.
  - req_ready[winner]=1; all other ready bits are 0.
  - req_ready may depend on req_valid. A requester must not make valid depend on ready, and must hold addr/data stable while valid is high.
- On a completed handshake:
  - Stage register ← {addr, data, wr=1}.
  - rr_ptr ← winner+1 (mod 4).
- No request in a cycle: stage wr ← 0, and rr_ptr holds.
- ZERO_R0=1 and addr=0:
  - The handshake still completes.
  - Stage wr ← 0.
  - drop_cnt increments, saturating at 255.
- clear_start in ARB:
  - No grant that cycle; clear takes priority over simultaneous requests.
  - Next state is CLEAR and clr_cnt ← 0.
- CLEAR:
  - req_ready=0 and clear_busy=1.
  - Each cycle stage ← {addr=clr_cnt, data=0, wr=1}, except wr=0 for addr 0 when ZERO_R0=1. Clear suppression does not count in drop_cnt.
  - clr_cnt increments each cycle. After issuing addr 31, return to ARB.
  - The total length is exactly 32 cycles.
- clear_start while in CLEAR is ignored.
- Output stage:
  - rf_write/rf_addr/rf_data load from the stage register on negedge clk.
  - They are therefore stable through the following clk-high phase, and the register file captures at the next posedge.

## Timing
- Handshake at posedge E0 → rf_* valid from the negedge after E0 → register file updated at posedge E1. Write-to-readback latency is 1 cycle after the handshake.
- Back-to-back grants are allowed every cycle. Sustained throughput is 1 write per cycle.
- clear_busy rises at the posedge that samples clear_start and falls at the posedge after addr 31 is staged.
- The last clear write lands in the register file one cycle after clear_busy falls.
- Reset values (asynchronous, immediate):
  - state=ARB, rr_ptr=0, clr_cnt=0.
  - Stage and rf_* cleared: rf_write=0, rf_addr=0, rf_data=0.
  - drop_cnt=0, clear_busy=0.
  - req_ready becomes purely combinational from req_valid after reset.
- Reset mid-clear aborts the sequence. No further clear writes are issued.
- rf_write must never change while clk is high. The bench checks this explicitly.

## Test plan
- Single request: req_valid=0001, addr=5, data=0xDEADBEEF → req_ready=0001 the same cycle; rf_write=1, rf_addr=5 after the next negedge; RegFile r5 reads 0xDEADBEEF one cycle after the handshake.
- All four valid continuously for 8 cycles, each requester using a distinct addr → grant order 0,1,2,3,0,1,2,3; eight writes, one per cycle, with no gaps.
- Requesters 1 and 3 valid after rr_ptr=2 → requester 3 is granted first and rr_ptr becomes 0; requester 1 is granted next.
- Requester 2 writes addr 0 with ZERO_R0=1 → handshake completes, rf_write stays 0, drop_cnt=1, and r0 reads 0.
- Preload r7=0x1234, then clear_start pulsed together with req_valid=1111 → no grant that cycle; clear_busy high for exactly 32 cycles; r7=0 afterwards; arbitration resumes from rr_ptr=0.
- reset low at clear cycle 10 → all outputs 0 immediately. After release, r11..r31 keep their previous values, and a new request is granted in the first cycle.
